// File: rtl/multi_byte_add_seq_pkg.sv
// Shared definitions for the byte-serial multi-precision adder:
// FSM state encoding and default geometry.
package multi_byte_add_seq_pkg;

    localparam int unsigned W_DEF     = 8;
    localparam int unsigned N_DEF     = 4;
    localparam int unsigned IDX_W_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Signed overflow of a slice: carry into the MSB differs from carry out of it.
    function automatic logic slice_overflow(input logic carry_into_msb, input logic carry_out);
        return carry_into_msb ^ carry_out;
    endfunction

endpackage

// File: rtl/multi_byte_add_seq_slice_adder.sv
// Combinational W-bit ripple-carry slice adder shared by all byte positions
// of the sequenced multi-precision add.
module slice_adder
    import multi_byte_add_seq_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_c0,
    output logic [W-1:0] o_sum,
    output logic         o_cout,
    output logic         o_overflow
);

    logic [W:0] w_c;

    // Bitwise ripple: w_c[i] is the carry into bit i.
    always_comb begin
        w_c    = '0;
        o_sum  = '0;
        w_c[0] = i_c0;
        for (int i = 0; i < W; i++) begin
            o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
            w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_cout     = w_c[W];
    assign o_overflow = slice_overflow(w_c[W-1], w_c[W]);

endmodule

// File: rtl/multi_byte_add_seq.sv
// Byte-serial multi-precision add/subtract: one shared slice adder walks the
// N slices of the latched operands, rippling the carry through a register.
module multi_byte_add_seq
    import multi_byte_add_seq_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned N     = N_DEF,
    parameter int unsigned IDX_W = IDX_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           sub,
    input  logic           cin,
    input  logic [W*N-1:0] a,
    input  logic [W*N-1:0] b,
    output logic           busy,
    output logic           done,
    output logic [W*N-1:0] sum,
    output logic           cout,
    output logic           overflow,
    output logic           zero
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [W*N-1:0]   r_a;
    logic [W*N-1:0]   r_b;
    logic [W*N-1:0]   r_sum;
    logic             r_cout;
    logic             r_overflow;
    logic             r_zero;
    logic             r_busy;
    logic             r_done;

    logic [W-1:0]     w_a_slice;
    logic [W-1:0]     w_b_slice;
    logic [W-1:0]     w_slice_sum;
    logic             w_slice_cout;
    logic             w_slice_ovf;
    logic [W*N-1:0]   w_sum_next;
    logic             w_last;

    assign w_last = (r_idx == IDX_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN for N cycles, one DONE cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Select the active slice of each operand and merge the slice result into the sum.
    always_comb begin
        w_a_slice  = r_a[W-1:0];
        w_b_slice  = r_b[W-1:0];
        w_sum_next = r_sum;
        for (int i = 0; i < N; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_a_slice              = r_a[i*W +: W];
                w_b_slice              = r_b[i*W +: W];
                w_sum_next[i*W +: W]   = w_slice_sum;
            end else begin
                w_sum_next[i*W +: W]   = r_sum[i*W +: W];
            end
        end
    end

    slice_adder #(
        .W (W)
    ) u_slice_adder (
        .i_a        (w_a_slice),
        .i_b        (w_b_slice),
        .i_c0       (r_carry),
        .o_sum      (w_slice_sum),
        .o_cout     (w_slice_cout),
        .o_overflow (w_slice_ovf)
    );

    // Operand capture, carry ripple and result/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a        <= a;
                        // Subtract as A + ~B + 1.
                        r_b        <= sub ? ~b : b;
                        r_carry    <= sub ? 1'b1 : cin;
                        r_idx      <= '0;
                        r_sum      <= '0;
                        r_cout     <= 1'b0;
                        r_overflow <= 1'b0;
                        r_zero     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_slice_cout;
                    if (w_last) begin
                        // Hold idx in range so it never wraps past N-1.
                        r_idx      <= '0;
                        r_cout     <= w_slice_cout;
                        r_overflow <= w_slice_ovf;
                        r_zero     <= (w_sum_next == '0);
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    r_idx <= '0;
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

    // Handshake outputs registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_next != ST_IDLE);
            r_done <= (w_state_next == ST_DONE);
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_overflow;
    assign zero     = r_zero;

endmodule
